control_stack_fsm: RTL and testbench
====================================

Name: control_stack_fsm

Overview:
- Next-generation control unit for the accumulator CPU: parametrised multi-cycle FETCH/EXEC state machine.
- Adds an instruction-memory ready handshake, a full set of Z/N conditional branches, CALL/RET through a hardware return-address stack, HLT, and sticky fault flags.
- Sits between instruction memory and the datapath (accumulator, ALU, status register, data memory) and drives all datapath control strobes.

Parameters:
- OPERAND_WIDTH, 11, operand field width; also the PC and instruction-address width.
- INSTRUCTION_WIDTH, 16, instruction word width; opcode = upper INSTRUCTION_WIDTH-OPERAND_WIDTH bits.
- STACK_DEPTH, 8, number of return-address entries (>=1).

Ports:
- clock_in  in  1  system clock, rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- instruction_in  in  INSTRUCTION_WIDTH  instruction word from instruction memory.
- instr_valid_in  in  1  instruction_in valid for the current instruction_address_out.
- status_Z_in  in  1  zero flag from the status register.
- status_N_in  in  1  negative flag from the status register.
- instruction_address_out  out  OPERAND_WIDTH  current PC.
- instr_req_out  out  1  fetch request.
- operand_out  out  OPERAND_WIDTH  IR operand field.
- sel_A_out  out  2  accumulator input select: 00 data memory, 01 ALU, 10 operand.
- sel_B_out  out  1  ALU B select: 0 data memory, 1 operand.
- alu_op_out  out  1  0 add, 1 subtract.
- data_memory_wr_out  out  1  data memory write strobe.
- acc_wr_out  out  1  accumulator write enable.
- status_wr_out  out  1  status register write enable.
- acc_reset_out  out  1  accumulator reset (equals reset_in).
- status_reset_out  out  1  status register reset (equals reset_in).
- halted_out  out  1  core halted.
- stack_overflow_out  out  1  sticky: CALL attempted with the stack full.
- stack_underflow_out  out  1  sticky: RET attempted with the stack empty.
- illegal_op_out  out  1  sticky: undefined opcode executed.

Behaviour:
- Reset (async, asserted): PC=0, IR=0, SP=0, state=FETCH, all sticky flags 0.
  - All strobes 0; instr_req_out=0; halted_out=0.
  - acc_reset_out and status_reset_out follow reset_in combinationally.
- States: FETCH, EXEC, HALT.
- FETCH:
  - instr_req_out=1; instruction_address_out=PC.
  - Wait while instr_valid_in=0 (PC held).
  - On valid: IR<=instruction_in; PC<=PC+1, modulo 2^OPERAND_WIDTH (wraps to 0); next state EXEC.
  - Minimum 2 cycles per instruction.
- EXEC (exactly one cycle):
  - Strobes are decoded combinationally from IR and are 0 in every other state.
  - Z/N are sampled in this cycle.
  - Default next state FETCH.
- Opcodes (values in package):
  - HLT=0: next state HALT.
  - STO=1: data_memory_wr=1.
  - LD=2: sel_A=00, acc_wr=1, status_wr=1.
  - LDI=3: sel_A=10, acc_wr=1, status_wr=1.
  - ADD=4 / ADDI=5: sel_A=01, sel_B=0/1, alu_op=0, acc_wr=1, status_wr=1.
  - SUB=6 / SUBI=7: as ADD/ADDI with alu_op=1.
  - Branches: BEQ=8 (Z), BNE=9 (!Z), BGT=10 (!Z&!N), BGE=11 (!N), BLT=12 (N), BLE=13 (Z|N), JMP=14 (always). Taken: PC<=operand. Not taken: PC keeps PC+1.
  - CALL=15: stack[SP]<=PC (already incremented = return address); SP<=SP+1; PC<=operand.
  - RET=16: SP<=SP-1; PC<=stack[SP-1].
  - NOP=17: no strobes.
  - Any other opcode: illegal_op<=1; next state HALT.
- Stack boundaries:
  - CALL with SP==STACK_DEPTH: no push; PC stays at the return address; stack_overflow<=1; next state HALT.
  - RET with SP==0: no pop; stack_underflow<=1; next state HALT.
  - A depth-D stack supports exactly D nested CALLs.
- HALT: halted_out=1; no requests, no strobes; PC and IR frozen. Exit only via reset.
- Reset mid-FETCH or mid-EXEC aborts immediately; a pending IR load or strobe is not completed.
- instr_valid_in is ignored outside FETCH.

Decomposition:
- Package control_pkg:
  - opcode enum (OPCODE_WIDTH = INSTRUCTION_WIDTH-OPERAND_WIDTH, codes above).
  - state enum {FETCH, EXEC, HALT}.
  - sel_A encodings (SEL_A_MEM, SEL_A_ALU, SEL_A_IMM).
  - ALU op constants.
- One sub-module, return_stack:
  - Parameters: depth, width.
  - Ports: push, pop, data in, top out, full, empty.
  - Async reset clears SP; entry contents need not be reset.

Test Plan:
- Reset, then instr_valid_in held 0 for 3 cycles -> instr_req_out=1, address 0, PC held. Present LDI 0x005 -> next cycle sel_A=10, acc_wr=1, status_wr=1, operand_out=0x005; then FETCH at address 1.
- BEQ 0x040 with Z=1 -> next fetch address 0x040. Repeat with Z=0 -> fetch address PC+1. Cover BGT/BLE with {Z,N}={0,0},{0,1},{1,0}.
- CALL 0x100 at address 0x010 -> fetch 0x100. RET at 0x100 -> fetch 0x011. Then nest 8 CALLs and 8 RETs -> correct unwinding, no flags.
- Ninth nested CALL (STACK_DEPTH=8) -> stack_overflow_out=1, halted_out=1, instr_req_out=0 forever. RET with empty stack -> stack_underflow_out=1, halted.
- JMP 0x7FF, then fetch at 0x7FF -> PC wraps to 0x000. Opcode 31 -> illegal_op_out=1, halted.
- Assert reset_in mid-EXEC of ADD -> strobes drop the same cycle (async), PC=0, flags cleared; acc_reset_out=status_reset_out=1 while reset_in=1.

Source files
------------

// File: rtl/control_pkg.sv
// Shared encodings for the accumulator CPU control unit: opcodes, FSM states and datapath selects.
package control_pkg;

  localparam int OPCODE_WIDTH = 5;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_HLT  = 5'd0,
    OP_STO  = 5'd1,
    OP_LD   = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7,
    OP_BEQ  = 5'd8,
    OP_BNE  = 5'd9,
    OP_BGT  = 5'd10,
    OP_BGE  = 5'd11,
    OP_BLT  = 5'd12,
    OP_BLE  = 5'd13,
    OP_JMP  = 5'd14,
    OP_CALL = 5'd15,
    OP_RET  = 5'd16,
    OP_NOP  = 5'd17
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_A_MEM = 2'b00;
  localparam logic [1:0] SEL_A_ALU = 2'b01;
  localparam logic [1:0] SEL_A_IMM = 2'b10;

  localparam logic SEL_B_MEM = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/return_stack.sv
// Return-address LIFO for CALL/RET; only the pointer is reset, entries hold whatever was last pushed.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SPW-1:0]   sp_q;
  logic [SPW-1:0]   sp_d;
  logic [SPW-1:0]   top_idx;

  assign full_o  = (sp_q == SPW'(DEPTH));
  assign empty_o = (sp_q == '0);
  assign top_idx = sp_q - SPW'(1);
  assign top_o   = mem_q[top_idx[AW-1:0]];

  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SPW'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SPW'(1);
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (push_i && !full_o) begin
      mem_q[sp_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/control_stack_fsm.sv
// Multi-cycle FETCH/EXEC controller for the accumulator CPU with a hardware return-address stack.
// state | meaning:  FETCH wait for instr_valid_in, load IR, PC+1 | EXEC one-cycle decode/strobes | HALT frozen until reset
module control_stack_fsm
  import control_pkg::*;
#(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int STACK_DEPTH       = 8
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction_in,
  input  logic                         instr_valid_in,
  input  logic                         status_Z_in,
  input  logic                         status_N_in,
  output logic [OPERAND_WIDTH-1:0]     instruction_address_out,
  output logic                         instr_req_out,
  output logic [OPERAND_WIDTH-1:0]     operand_out,
  output logic [1:0]                   sel_A_out,
  output logic                         sel_B_out,
  output logic                         alu_op_out,
  output logic                         data_memory_wr_out,
  output logic                         acc_wr_out,
  output logic                         status_wr_out,
  output logic                         acc_reset_out,
  output logic                         status_reset_out,
  output logic                         halted_out,
  output logic                         stack_overflow_out,
  output logic                         stack_underflow_out,
  output logic                         illegal_op_out
);

  state_e                         state_q, state_d;
  logic [OPERAND_WIDTH-1:0]       pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0]   ir_q, ir_d;
  logic                           ovf_q, ovf_d;
  logic                           unf_q, unf_d;
  logic                           ill_q, ill_d;

  logic [OPCODE_WIDTH-1:0]        opcode;
  logic [OPERAND_WIDTH-1:0]       operand;
  logic                           taken;
  logic                           push, pop;
  logic                           stack_full, stack_empty;
  logic [OPERAND_WIDTH-1:0]       stack_top;

  assign opcode  = ir_q[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  assign operand = ir_q[OPERAND_WIDTH-1:0];

  assign instruction_address_out = pc_q;
  assign operand_out             = operand;
  assign acc_reset_out           = reset_in;
  assign status_reset_out        = reset_in;
  assign stack_overflow_out      = ovf_q;
  assign stack_underflow_out     = unf_q;
  assign illegal_op_out          = ill_q;

  // pc_q is already the return address when a CALL executes
  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (OPERAND_WIDTH)
  ) u_return_stack (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .push_i   (push),
    .pop_i    (pop),
    .data_i   (pc_q),
    .top_o    (stack_top),
    .full_o   (stack_full),
    .empty_o  (stack_empty)
  );

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = status_Z_in;
      OP_BNE:  taken = !status_Z_in;
      OP_BGT:  taken = !status_Z_in && !status_N_in;
      OP_BGE:  taken = !status_N_in;
      OP_BLT:  taken = status_N_in;
      OP_BLE:  taken = status_Z_in || status_N_in;
      OP_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    ir_d               = ir_q;
    ovf_d              = ovf_q;
    unf_d              = unf_q;
    ill_d              = ill_q;
    push               = 1'b0;
    pop                = 1'b0;
    instr_req_out      = 1'b0;
    sel_A_out          = SEL_A_MEM;
    sel_B_out          = SEL_B_MEM;
    alu_op_out         = ALU_ADD;
    data_memory_wr_out = 1'b0;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    halted_out         = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // request is masked while reset is held so it drops with the reset edge
        instr_req_out = !reset_in;
        if (instr_valid_in) begin
          ir_d    = instruction_in;
          pc_d    = pc_q + OPERAND_WIDTH'(1);
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_HLT: state_d = ST_HALT;
          OP_STO: data_memory_wr_out = 1'b1;
          OP_LD: begin
            sel_A_out     = SEL_A_MEM;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_LDI: begin
            sel_A_out     = SEL_A_IMM;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            sel_A_out     = SEL_A_ALU;
            sel_B_out     = (opcode == OP_ADDI || opcode == OP_SUBI) ? SEL_B_IMM : SEL_B_MEM;
            alu_op_out    = (opcode == OP_SUB || opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
            acc_wr_out    = 1'b1;
            status_wr_out = 1'b1;
          end
          OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
            if (taken) begin
              pc_d = operand;
            end
          end
          OP_CALL: begin
            if (stack_full) begin
              ovf_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              push = 1'b1;
              pc_d = operand;
            end
          end
          OP_RET: begin
            if (stack_empty) begin
              unf_d   = 1'b1;
              state_d = ST_HALT;
            end else begin
              pop  = 1'b1;
              pc_d = stack_top;
            end
          end
          OP_NOP: ;
          default: begin
            ill_d   = 1'b1;
            state_d = ST_HALT;
          end
        endcase
      end

      ST_HALT: halted_out = 1'b1;

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      ill_q   <= ill_d;
    end
  end

endmodule

// File: tb/tb_control_stack_fsm.sv
// Scoreboard bench for control_stack_fsm: a driver feeds instructions, a PC/stack model predicts results, a monitor compares.
module tb_control_stack_fsm;

  localparam int OW = 11;
  localparam int IW = 16;
  localparam int SD = 8;

  logic          clock_in = 1'b0;
  logic          reset_in = 1'b1;
  logic [IW-1:0] instruction_in = '0;
  logic          instr_valid_in = 1'b0;
  logic          status_Z_in = 1'b0;
  logic          status_N_in = 1'b0;
  logic [OW-1:0] instruction_address_out;
  logic          instr_req_out;
  logic [OW-1:0] operand_out;
  logic [1:0]    sel_A_out;
  logic          sel_B_out, alu_op_out, data_memory_wr_out, acc_wr_out, status_wr_out;
  logic          acc_reset_out, status_reset_out, halted_out;
  logic          stack_overflow_out, stack_underflow_out, illegal_op_out;

  control_stack_fsm #(
    .OPERAND_WIDTH     (OW),
    .INSTRUCTION_WIDTH (IW),
    .STACK_DEPTH       (SD)
  ) dut (
    .clock_in                (clock_in),
    .reset_in                (reset_in),
    .instruction_in          (instruction_in),
    .instr_valid_in          (instr_valid_in),
    .status_Z_in             (status_Z_in),
    .status_N_in             (status_N_in),
    .instruction_address_out (instruction_address_out),
    .instr_req_out           (instr_req_out),
    .operand_out             (operand_out),
    .sel_A_out               (sel_A_out),
    .sel_B_out               (sel_B_out),
    .alu_op_out              (alu_op_out),
    .data_memory_wr_out      (data_memory_wr_out),
    .acc_wr_out              (acc_wr_out),
    .status_wr_out           (status_wr_out),
    .acc_reset_out           (acc_reset_out),
    .status_reset_out        (status_reset_out),
    .halted_out              (halted_out),
    .stack_overflow_out      (stack_overflow_out),
    .stack_underflow_out     (stack_underflow_out),
    .illegal_op_out          (illegal_op_out)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    int sa, sb, aop, dmw, accw, stw;
    int opnd, npc, halt, ovf, unf, ill;
  } exp_t;

  exp_t exec_q[$];
  int   addr_q[$];

  int   m_pc;
  int   m_stack[$];
  bit   m_halted, m_ovf, m_unf, m_ill;

  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural reference: PC arithmetic modulo 2048, return stack as a queue of at most SD entries.
  task automatic model_exec(input int op, input int opnd, input bit z, input bit n, output exp_t e);
    bit tk;
    e = '{default: 0};
    e.opnd = opnd;
    tk = 1'b0;
    case (op)
      0: m_halted = 1'b1;
      1: e.dmw = 1;
      2: begin e.sa = 0; e.accw = 1; e.stw = 1; end
      3: begin e.sa = 2; e.accw = 1; e.stw = 1; end
      4, 5, 6, 7: begin
        e.sa   = 1;
        e.sb   = (op == 5 || op == 7) ? 1 : 0;
        e.aop  = (op >= 6) ? 1 : 0;
        e.accw = 1;
        e.stw  = 1;
      end
      8, 9, 10, 11, 12, 13, 14: begin
        case (op)
          8:       tk = z;
          9:       tk = !z;
          10:      tk = !z && !n;
          11:      tk = !n;
          12:      tk = n;
          13:      tk = z || n;
          default: tk = 1'b1;
        endcase
        if (tk) m_pc = opnd;
      end
      15: begin
        if (m_stack.size() >= SD) begin
          m_ovf = 1'b1;
          m_halted = 1'b1;
        end else begin
          m_stack.push_back(m_pc);
          m_pc = opnd;
        end
      end
      16: begin
        if (m_stack.size() == 0) begin
          m_unf = 1'b1;
          m_halted = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end
      17: ;
      default: begin
        m_ill = 1'b1;
        m_halted = 1'b1;
      end
    endcase
    e.npc  = m_pc;
    e.halt = m_halted;
    e.ovf  = m_ovf;
    e.unf  = m_unf;
    e.ill  = m_ill;
  endtask

  task automatic wait_fetch();
    int waited = 0;
    while (!instr_req_out && waited < 20) begin
      @(posedge clock_in); #2;
      waited++;
    end
    chk("fetch_request_seen", instr_req_out, 1);
  endtask

  // Called at posedge+2 of a FETCH cycle; returns at posedge+2 of the cycle after EXEC.
  task automatic issue(input int op, input int opnd, input int gap, input int z, input int n);
    exp_t e;
    if (m_halted) return;
    wait_fetch();
    if (!instr_req_out) return;
    addr_q.push_back(m_pc);
    repeat (gap) begin
      instr_valid_in = 1'b0;
      instruction_in = IW'($urandom);
      @(posedge clock_in); #2;
    end
    instr_valid_in = 1'b1;
    instruction_in = IW'((op << OW) | (opnd & 'h7FF));
    m_pc = (m_pc + 1) % (1 << OW);
    @(posedge clock_in); #2;
    instr_valid_in = 1'($urandom);
    instruction_in = IW'($urandom);
    status_Z_in    = z[0];
    status_N_in    = n[0];
    model_exec(op, opnd, z[0], n[0], e);
    exec_q.push_back(e);
    @(posedge clock_in); #2;
    instr_valid_in = 1'b0;
    status_Z_in    = 1'($urandom);
    status_N_in    = 1'($urandom);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      instr_valid_in = m_halted ? 1'($urandom) : 1'b0;
      instruction_in = IW'($urandom);
      @(posedge clock_in); #2;
    end
    instr_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    #1;
    chk("rst_acc_reset", acc_reset_out, 1);
    chk("rst_status_reset", status_reset_out, 1);
    chk("rst_req", instr_req_out, 0);
    chk("rst_halted", halted_out, 0);
    chk("rst_addr", instruction_address_out, 0);
    chk("rst_operand", operand_out, 0);
    chk("rst_flags", {stack_overflow_out, stack_underflow_out, illegal_op_out}, 0);
    chk("rst_strobes", {data_memory_wr_out, acc_wr_out, status_wr_out}, 0);
    @(posedge clock_in); #2;
    reset_in = 1'b0;
    #1;
    chk("rst_release_acc_reset", acc_reset_out, 0);
    m_pc = 0;
    m_stack.delete();
    m_halted = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_ill = 1'b0;
    addr_q.delete();
    exec_q.delete();
  endtask

  // Reset lands in the middle of an ADD's EXEC cycle; its strobes must vanish at once.
  task automatic abort_add(input int opnd);
    wait_fetch();
    if (!instr_req_out) return;
    addr_q.push_back(m_pc);
    instr_valid_in = 1'b1;
    instruction_in = IW'((4 << OW) | opnd);
    @(posedge clock_in); #2;
    instr_valid_in = 1'b0;
    chk("abort_acc_wr_before", acc_wr_out, 1);
    chk("abort_sel_A_before", sel_A_out, 1);
    reset_in = 1'b1;
    #1;
    chk("abort_acc_wr", acc_wr_out, 0);
    chk("abort_status_wr", status_wr_out, 0);
    chk("abort_sel_A", sel_A_out, 0);
    chk("abort_pc", instruction_address_out, 0);
    chk("abort_acc_reset", acc_reset_out, 1);
    chk("abort_status_reset", status_reset_out, 1);
    do_reset();
  endtask

  // Monitor: address checked whenever a fetch is requested, strobes when an EXEC was scheduled.
  initial begin
    exp_t e, pe;
    bit   post_pending = 1'b0;
    bit   mon_halted = 1'b0;
    forever begin
      @(negedge clock_in);
      if (post_pending) begin
        post_pending = 1'b0;
        chk("post_halted", halted_out, pe.halt);
        chk("post_req", instr_req_out, pe.halt ? 0 : 1);
        chk("post_pc", instruction_address_out, pe.npc);
        chk("post_overflow", stack_overflow_out, pe.ovf);
        chk("post_underflow", stack_underflow_out, pe.unf);
        chk("post_illegal", illegal_op_out, pe.ill);
        mon_halted = pe.halt[0];
      end
      if (exec_q.size() > 0) begin
        e = exec_q.pop_front();
        chk("exec_sel_A", sel_A_out, e.sa);
        chk("exec_sel_B", sel_B_out, e.sb);
        chk("exec_alu_op", alu_op_out, e.aop);
        chk("exec_dmem_wr", data_memory_wr_out, e.dmw);
        chk("exec_acc_wr", acc_wr_out, e.accw);
        chk("exec_status_wr", status_wr_out, e.stw);
        chk("exec_operand", operand_out, e.opnd);
        pe = e;
        post_pending = 1'b1;
      end else begin
        chk("idle_strobes", {sel_A_out, sel_B_out, alu_op_out, data_memory_wr_out, acc_wr_out, status_wr_out}, 0);
        if (mon_halted && !reset_in) begin
          chk("halt_stays", halted_out, 1);
          chk("halt_no_req", instr_req_out, 0);
        end
      end
      if (instr_req_out && addr_q.size() > 0) begin
        chk("fetch_addr", instruction_address_out, addr_q[0]);
        if (instr_valid_in) void'(addr_q.pop_front());
      end
      if (reset_in) begin
        mon_halted = 1'b0;
        post_pending = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, r;
    repeat (2) @(posedge clock_in);
    #2;
    do_reset();

    issue(3, 'h005, 3, 0, 0);
    issue(8, 'h040, 0, 1, 0);
    issue(8, 'h055, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      issue(10, 'h200 + k, 0, (k == 2) ? 1 : 0, (k == 1) ? 1 : 0);
      issue(13, 'h300 + k, 0, (k == 2) ? 1 : 0, (k == 1) ? 1 : 0);
    end
    issue(14, 'h010, 1, 0, 0);
    issue(15, 'h100, 0, 0, 0);
    issue(16, 'h000, 0, 0, 0);
    for (int k = 0; k < SD; k++) issue(15, 'h100 + 16 * k, $urandom_range(0, 2), 0, 0);
    for (int k = 0; k < SD; k++) issue(16, 0, $urandom_range(0, 2), 0, 0);
    for (int k = 0; k < SD + 1; k++) issue(15, 'h400 + 8 * k, 0, 0, 0);
    idle(5);
    do_reset();

    issue(16, 0, 0, 0, 0);
    idle(3);
    do_reset();

    issue(14, 'h7FF, 0, 0, 0);
    issue(17, 'h000, 0, 0, 0);
    issue(17, 'h000, 0, 0, 0);
    issue(31, 'h123, 0, 0, 0);
    idle(3);
    do_reset();

    issue(1, 'h0AA, 0, 0, 0);
    issue(2, 'h0BB, 0, 0, 0);
    issue(5, 'h011, 0, 0, 0);
    issue(7, 'h022, 0, 0, 0);
    issue(6, 'h033, 0, 0, 0);
    issue(0, 'h000, 0, 0, 0);
    idle(3);
    do_reset();
    issue(3, 'h045, 0, 0, 0);
    abort_add('h1A5);

    for (int k = 0; k < 300; k++) begin
      if (m_halted) begin
        idle(2);
        do_reset();
      end
      r = $urandom_range(0, 99);
      if (r < 2) op = 0;
      else if (r < 4) op = $urandom_range(18, 31);
      else if (r < 12) op = 16;
      else if (r < 24) op = 15;
      else begin
        op = $urandom_range(1, 15);
        if (op == 15) op = 17;
      end
      issue(op, $urandom_range(0, (1 << OW) - 1), $urandom_range(0, 2),
            $urandom_range(0, 1), $urandom_range(0, 1));
    end
    idle(4);
    chk("queues_drained", exec_q.size() + addr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
